// File: rtl/iter_shifter_if.sv
// Handshake/data bundle for iter_shifter: request side (start/operand/amount/mode)
// and response side (ready/valid/result).
interface iter_shifter_if #(
   parameter int unsigned WIDTH = 17
);
   localparam int unsigned SW = $clog2(WIDTH) + 1;

   logic             start_i;
   logic [WIDTH-1:0] in_i;
   logic [SW-1:0]    shamt_i;
   logic [1:0]       mode_i;
   logic             ready_o;
   logic             valid_o;
   logic [WIDTH-1:0] out_o;

   modport master (
      output start_i, in_i, shamt_i, mode_i,
      input  ready_o, valid_o, out_o
   );

   modport slave (
      input  start_i, in_i, shamt_i, mode_i,
      output ready_o, valid_o, out_o
   );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle LSL/LSR/ASR shifter moving at most STEP bits per clock.
// Define SHIFTER_ROTATE_EN to turn mode 2'b11 into ROL; otherwise it aliases LSL.
module iter_shifter #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned STEP  = 2
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   iter_shifter_if.slave  bus
);
   localparam int unsigned SW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_data_step;
   logic [SW-1:0]    r_rem;
   logic [SW-1:0]    w_rem_nxt;
   logic [SW-1:0]    w_count;
   logic [SW-1:0]    w_step;
   logic [1:0]       r_mode;
   logic [1:0]       w_mode_eff;
   logic             r_ready;
   logic             r_valid;
   logic             w_accept;

   assign w_accept = bus.start_i & r_ready;

   // Effective mode and total shift count; non-rotate amounts saturate at WIDTH.
   always_comb begin
      w_mode_eff = bus.mode_i;
      if (bus.shamt_i > SW'(WIDTH)) w_count = SW'(WIDTH);
      else                          w_count = bus.shamt_i;
`ifdef SHIFTER_ROTATE_EN
      if (bus.mode_i == 2'b11) w_count = bus.shamt_i;
`else
      if (bus.mode_i == 2'b11) w_mode_eff = 2'b00;
`endif
   end

   assign w_step = (r_rem < SW'(STEP)) ? r_rem : SW'(STEP);

   // Narrow per-cycle network: one constant-shift leg per legal step size.
   always_comb begin
      w_data_step = r_data;
      for (int k = 1; k <= int'(STEP); k++) begin
         if (w_step == SW'(k)) begin
            case (r_mode)
               2'b01:   w_data_step = r_data >> k;
               2'b10:   w_data_step = WIDTH'($signed(r_data) >>> k);
`ifdef SHIFTER_ROTATE_EN
               2'b11:   w_data_step = (r_data << k) | (r_data >> (int'(WIDTH) - k));
`endif
               default: w_data_step = r_data << k;
            endcase
         end
      end
   end

   // Next-state and remaining-count logic.
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_rem_nxt   = w_count;
               w_state_nxt = (w_count == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_rem_nxt = r_rem - w_step;
            if (w_rem_nxt == '0) w_state_nxt = ST_DONE;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Datapath and registered handshake outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data  <= '0;
         r_rem   <= '0;
         r_mode  <= 2'b00;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
      end else begin
         r_rem   <= w_rem_nxt;
         r_ready <= (w_state_nxt == ST_IDLE);
         r_valid <= (w_state_nxt == ST_DONE);
         if (r_state == ST_IDLE && w_accept) begin
            r_data <= bus.in_i;
            r_mode <= w_mode_eff;
         end else if (r_state == ST_SHIFT) begin
            r_data <= w_data_step;
         end
      end
   end

   assign bus.ready_o = r_ready;
   assign bus.valid_o = r_valid;
   assign bus.out_o   = r_data;
endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: directed cases plus random ops checked
// against an arithmetic reference model for result and latency.
module tb_iter_shifter;
   localparam int W    = 17;
   localparam int STEP = 2;
   localparam int SW   = $clog2(W) + 1;

   typedef struct {
      logic [W-1:0] data;
      int           acc;
      int           n;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_errors;
   exp_t exp_q[$];

   iter_shifter_if #(.WIDTH(W)) bus ();

   iter_shifter #(.WIDTH(W), .STEP(STEP)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: plain arithmetic shifts with saturation; rotate by repeated 1-bit rotation.
   function automatic logic [W-1:0] model(input logic [W-1:0] x, input int sh,
                                          input logic [1:0] m, output int n);
      logic [W-1:0] r;
      logic [W-1:0] nx;
      logic [1:0]   mm;
      int           cnt;
      mm  = m;
      cnt = (sh > W) ? W : sh;
      r   = x;
`ifdef SHIFTER_ROTATE_EN
      if (m == 2'b11) begin
         cnt = sh;
         repeat (sh) r = {r[W-2:0], r[W-1]};
      end
`else
      if (m == 2'b11) mm = 2'b00;
`endif
      nx = ~x;
      case (mm)
         2'b00:   r = x << cnt;
         2'b01:   r = x >> cnt;
         2'b10:   r = x[W-1] ? ~(nx >> cnt) : (x >> cnt);
         default: ;
      endcase
      n = (cnt + STEP - 1) / STEP;
      return r;
   endfunction

   // Monitor: every valid pulse must match the oldest expected result and latency.
   always @(negedge clk) begin
      if (rst_n && bus.valid_o) begin
         chk("valid_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data", 64'(bus.out_o), 64'(e.data));
            chk("latency", 64'(cyc - e.acc), 64'(e.n));
         end
      end
   end

   // Issue one op from a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [W-1:0] x, input int sh, input logic [1:0] m,
                        input bit hold, output int n);
      int   waitc;
      exp_t e;
      waitc = 0;
      while (!bus.ready_o && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      if (!bus.ready_o) begin
         chk("ready_timeout", 64'd0, 64'd1);
         n = 0;
         return;
      end
      bus.in_i    = x;
      bus.shamt_i = SW'(sh);
      bus.mode_i  = m;
      bus.start_i = 1'b1;
      e.data = model(x, sh, m, n);
      e.acc  = cyc + 1;
      e.n    = n;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) bus.start_i = 1'b0;
      bus.in_i    = W'($urandom);
      bus.shamt_i = SW'($urandom);
      bus.mode_i  = 2'($urandom);
      @(negedge clk);
   endtask

   // ready_o must stay low for n+1 cycles after the accept, then return high.
   task automatic wait_done(input int n);
      for (int i = 0; i <= n; i++) begin
         chk("ready_busy", 64'(bus.ready_o), 64'd0);
         @(negedge clk);
      end
      chk("ready_back", 64'(bus.ready_o), 64'd1);
      bus.start_i = 1'b0;
   endtask

   initial begin
      int n;
      int waitc;
      n_checks    = 0;
      n_errors    = 0;
      rst_n       = 1'b0;
      bus.start_i = 1'b0;
      bus.in_i    = '0;
      bus.shamt_i = '0;
      bus.mode_i  = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_out", 64'(bus.out_o), 64'd0);
      chk("rst_valid", 64'(bus.valid_o), 64'd0);
      chk("rst_ready", 64'(bus.ready_o), 64'd1);
      rst_n = 1'b1;

      issue(17'h00001, 2, 2'b00, 1'b0, n); wait_done(n);
      issue(17'h1FFFF, 17, 2'b00, 1'b0, n); wait_done(n);
      issue(17'h1FFFF, 40, 2'b00, 1'b0, n); wait_done(n);
      issue(17'h10000, 4, 2'b10, 1'b0, n); wait_done(n);
      issue(17'h00010, 3, 2'b01, 1'b0, n); wait_done(n);
      issue(17'h0ABCD, 0, 2'b00, 1'b1, n); wait_done(n);
      issue(17'h00005, 7, 2'b00, 1'b1, n); wait_done(n);
      issue(17'h10001, 1, 2'b11, 1'b0, n); wait_done(n);
`ifdef SHIFTER_ROTATE_EN
      issue(17'h10001, 17, 2'b11, 1'b0, n); wait_done(n);
      issue(17'h12345, 40, 2'b11, 1'b0, n); wait_done(n);
`endif

      // Reset in the middle of a long shift discards the op.
      issue(17'h0F0F1, 16, 2'b00, 1'b0, n);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out", 64'(bus.out_o), 64'd0);
      chk("midrst_valid", 64'(bus.valid_o), 64'd0);
      chk("midrst_ready", 64'(bus.ready_o), 64'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      repeat (150) begin
         issue(W'($urandom), int'($urandom_range(0, (1 << SW) - 1)),
               2'($urandom_range(0, 3)), 1'b0, n);
      end

      waitc = 0;
      while ((exp_q.size() != 0 || !bus.ready_o) && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      chk("drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
